// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and the shift-mode classifier used to qualify burst requests.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    LOAD  = 3'b001,
    SHL   = 3'b010,
    SHR   = 3'b011,
    ROL   = 3'b100,
    ROR   = 3'b101,
    CLEAR = 3'b110,
    RSVD  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic is_shift_mode(input mode_e m);
    logic r;
    case (m)
      SHL, SHR, ROL, ROR: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value mux for the shift register; one instance serves
// both the per-cycle mode path and the autonomous burst path.
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] q_next
);

  mode_e op_s;

  assign op_s = mode_e'(op);

  // Select the new register value for the requested operation.
  always_comb begin
    q_next = q;
    case (op_s)
      HOLD:    q_next = q;
      LOAD:    q_next = d;
      SHL:     q_next = {q[WIDTH-2:0], sin_r};
      SHR:     q_next = {sin_l, q[WIDTH-1:1]};
      ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:     q_next = {q[0], q[WIDTH-1:1]};
      CLEAR:   q_next = {WIDTH{1'b0}};
      RSVD:    q_next = q;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/load/shift/rotate/clear modes and an
// autonomous burst engine that shifts a programmed number of bits.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] nbits,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  mode_e            mode_s;
  mode_e            op_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CNT_W-1:0] clamp_s;

  logic [WIDTH-1:0] q_r,        q_nxt_s;
  state_e           state_r,    state_nxt_s;
  logic [CNT_W-1:0] count_r,    count_nxt_s;
  mode_e            burst_op_r, burst_op_nxt_s;
  logic             done_r,     done_nxt_s;
  logic             busy_r,     busy_nxt_s;

  assign mode_s  = mode_e'(mode);
  assign op_s    = (state_r == BURST) ? burst_op_r : mode_s;
  assign clamp_s = (nbits > WIDTH_C) ? WIDTH_C : nbits;

  usr_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .q      (q_r),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .op     (op_s),
    .q_next (shifted_s)
  );

  // Next-state, counter and data decisions for the IDLE/BURST engine.
  always_comb begin
    q_nxt_s        = q_r;
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    burst_op_nxt_s = burst_op_r;
    done_nxt_s     = 1'b0;
    if (en) begin
      case (state_r)
        IDLE: begin
          if (start && is_shift_mode(mode_s)) begin
            // q is left untouched on the edge that arms a burst.
            burst_op_nxt_s = mode_s;
            count_nxt_s    = clamp_s;
            if (clamp_s != ZERO_C) begin
              state_nxt_s = BURST;
            end else begin
              done_nxt_s = 1'b1;
            end
          end else begin
            q_nxt_s = shifted_s;
          end
        end
        BURST: begin
          q_nxt_s     = shifted_s;
          count_nxt_s = count_r - ONE_C;
          if (count_r == ONE_C) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = BURST;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          count_nxt_s = ZERO_C;
        end
      endcase
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  assign busy_nxt_s = (state_nxt_s == BURST);

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= {WIDTH{1'b0}};
      state_r    <= IDLE;
      count_r    <= ZERO_C;
      burst_op_r <= HOLD;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      q_r        <= q_nxt_s;
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      burst_op_r <= burst_op_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign q      = q_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];
  assign busy   = busy_r;
  assign done   = done_r;

endmodule
